// File: rtl/seq_gen_pkg.sv
// Shared types and width helpers for the seq_gen serial pattern transmitter.
package seq_gen_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SEND = 2'd1,
    S_GAP  = 2'd2,
    S_DONE = 2'd3
  } state_e;

  // Counter width for values 0..n-1, never narrower than one bit.
  function automatic int width_min1(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/seq_piso.sv
// Parallel-load shift register; serial output is the MSB register bit.
module seq_piso #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic         shift,
  input  logic         clear,
  input  logic [W-1:0] pdata,
  output logic         sout
);

  logic [W-1:0] sr_q;

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      sr_q <= '0;
    end else if (load) begin
      sr_q <= pdata;
    end else if (shift) begin
      sr_q <= sr_q << 1;
    end else begin
      sr_q <= sr_q;
    end
  end

  assign sout = sr_q[W-1];

endmodule

// File: rtl/seq_gen.sv
// Serial test-pattern transmitter: sends PATTERN MSB first, rep_cnt times,
// with GAP_LEN idle bits between frames and a mark pulse on each last bit.
module seq_gen
  import seq_gen_pkg::*;
#(
  parameter int                 PAT_LEN = 4,
  parameter logic [PAT_LEN-1:0] PATTERN = 4'b1101,
  parameter int                 GAP_LEN = 2,
  parameter int                 CNT_W   = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [CNT_W-1:0] rep_cnt,
  input  logic             abort,
  output logic             dout,
  output logic             valid,
  output logic             mark,
  output logic             busy,
  output logic             done
);

  localparam int IDX_W = width_min1(PAT_LEN);
  localparam int GAP_W = width_min1(GAP_LEN + 1);

  state_e           state_q;
  logic [IDX_W-1:0] idx_q;
  logic [CNT_W-1:0] rem_q;
  logic [CNT_W-1:0] rem_d;
  logic [GAP_W-1:0] gap_q;
  logic             valid_q, mark_q, busy_q, done_q;
  logic             load_s, shift_s, clear_s, more_s;

  // Saturating decrement: the frame counter never wraps.
  assign rem_d  = (rem_q != {CNT_W{1'b0}}) ? rem_q - CNT_W'(1) : rem_q;
  assign more_s = (rem_d != {CNT_W{1'b0}});

  // Shift-register control mirrors the FSM transitions below; clearing it
  // whenever a frame ends keeps dout at 0 outside SEND.
  always_comb begin
    load_s  = 1'b0;
    shift_s = 1'b0;
    clear_s = 1'b0;
    case (state_q)
      S_IDLE: load_s = start && (rep_cnt != {CNT_W{1'b0}});
      S_SEND: begin
        if (abort)                                 clear_s = 1'b1;
        else if (idx_q != {IDX_W{1'b0}})           shift_s = 1'b1;
        else if (more_s && (GAP_LEN == 0))         load_s  = 1'b1;
        else                                       clear_s = 1'b1;
      end
      S_GAP: begin
        if (abort)                                 clear_s = 1'b1;
        else if (gap_q == {GAP_W{1'b0}})           load_s  = 1'b1;
        else                                       clear_s = 1'b0;
      end
      default: clear_s = 1'b0;
    endcase
  end

  seq_piso #(.W(PAT_LEN)) u_piso (
    .clk   (clk),
    .rst   (rst),
    .load  (load_s),
    .shift (shift_s),
    .clear (clear_s),
    .pdata (PATTERN),
    .sout  (dout)
  );

  // Main FSM with registered status outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      rem_q   <= '0;
      gap_q   <= '0;
      valid_q <= 1'b0;
      mark_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      mark_q <= 1'b0;
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start) begin
            rem_q <= rep_cnt;
            if (rep_cnt == {CNT_W{1'b0}}) begin
              state_q <= S_DONE;
              done_q  <= 1'b1;
            end else begin
              state_q <= S_SEND;
              idx_q   <= IDX_W'(PAT_LEN - 1);
              valid_q <= 1'b1;
              busy_q  <= 1'b1;
              mark_q  <= (PAT_LEN == 1);
            end
          end
        end
        S_SEND: begin
          if (abort) begin
            state_q <= S_IDLE;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
          end else if (idx_q != {IDX_W{1'b0}}) begin
            idx_q  <= idx_q - IDX_W'(1);
            mark_q <= (idx_q == IDX_W'(1));
          end else begin
            rem_q <= rem_d;
            if (!more_s) begin
              state_q <= S_DONE;
              valid_q <= 1'b0;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end else if (GAP_LEN > 0) begin
              state_q <= S_GAP;
              gap_q   <= GAP_W'(GAP_LEN > 0 ? GAP_LEN - 1 : 0);
              valid_q <= 1'b0;
            end else begin
              idx_q  <= IDX_W'(PAT_LEN - 1);
              mark_q <= (PAT_LEN == 1);
            end
          end
        end
        S_GAP: begin
          if (abort) begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
          end else if (gap_q == {GAP_W{1'b0}}) begin
            state_q <= S_SEND;
            idx_q   <= IDX_W'(PAT_LEN - 1);
            valid_q <= 1'b1;
            mark_q  <= (PAT_LEN == 1);
          end else begin
            gap_q <= gap_q - GAP_W'(1);
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
          valid_q <= 1'b0;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= S_IDLE;
          valid_q <= 1'b0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign valid = valid_q;
  assign mark  = mark_q;
  assign busy  = busy_q;
  assign done  = done_q;

endmodule

// File: tb/tb_seq_gen.sv
// Scoreboard bench for seq_gen: one instance with a 2-bit gap, one back-to-back.
module tb_seq_gen;

  logic       clk = 1'b0;
  logic       rst, start_g, start_b, abort;
  logic [3:0] rep_cnt;
  logic       dout_g, valid_g, mark_g, busy_g, done_g;
  logic       dout_b, valid_b, mark_b, busy_b, done_b;

  typedef struct {
    logic [4:0] v;   // {dout, valid, mark, busy, done}
    string      tag;
  } exp_t;

  exp_t q_g[$];
  exp_t q_b[$];
  int   errors = 0;
  int   checks = 0;

  localparam logic [4:0] V_ONE  = 5'b11010;
  localparam logic [4:0] V_ZERO = 5'b01010;
  localparam logic [4:0] V_LAST = 5'b11110;
  localparam logic [4:0] V_GAP  = 5'b00010;
  localparam logic [4:0] V_DONE = 5'b00001;
  localparam logic [4:0] V_IDLE = 5'b00000;

  always #5 clk = ~clk;

  seq_gen #(.PAT_LEN(4), .PATTERN(4'b1101), .GAP_LEN(2), .CNT_W(4)) u_gap (
    .clk(clk), .rst(rst), .start(start_g), .rep_cnt(rep_cnt), .abort(abort),
    .dout(dout_g), .valid(valid_g), .mark(mark_g), .busy(busy_g), .done(done_g)
  );

  seq_gen #(.PAT_LEN(4), .PATTERN(4'b1101), .GAP_LEN(0), .CNT_W(4)) u_b2b (
    .clk(clk), .rst(rst), .start(start_b), .rep_cnt(rep_cnt), .abort(abort),
    .dout(dout_b), .valid(valid_b), .mark(mark_b), .busy(busy_b), .done(done_b)
  );

  task automatic push(input bit b2b, input logic [4:0] v, input string tag, input int n);
    exp_t e;
    e.v   = v;
    e.tag = tag;
    for (int i = 0; i < n; i++) begin
      if (b2b) q_b.push_back(e);
      else     q_g.push_back(e);
    end
  endtask

  // Pattern 1101: bits 1,1,0,1 with mark on the last one.
  task automatic frame(input bit b2b, input string tag);
    push(b2b, V_ONE, tag, 2);
    push(b2b, V_ZERO, tag, 1);
    push(b2b, V_LAST, tag, 1);
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  // Monitor: one expected vector per cycle while a queue holds entries.
  always @(negedge clk) begin : monitor
    exp_t e;
    if (q_g.size() > 0) begin
      e = q_g.pop_front();
      checks++;
      if ({dout_g, valid_g, mark_g, busy_g, done_g} !== e.v) begin
        errors++;
        $display("FAIL %s gap_dut t=%0t got=%b expected=%b", e.tag, $time,
                 {dout_g, valid_g, mark_g, busy_g, done_g}, e.v);
      end
    end
    if (q_b.size() > 0) begin
      e = q_b.pop_front();
      checks++;
      if ({dout_b, valid_b, mark_b, busy_b, done_b} !== e.v) begin
        errors++;
        $display("FAIL %s b2b_dut t=%0t got=%b expected=%b", e.tag, $time,
                 {dout_b, valid_b, mark_b, busy_b, done_b}, e.v);
      end
    end
  end

  initial begin
    rst = 1'b1; start_g = 1'b1; start_b = 1'b1; abort = 1'b0; rep_cnt = 4'd5;
    push(1'b0, V_IDLE, "reset", 3);
    push(1'b1, V_IDLE, "reset", 3);
    wait_cyc(3);
    rst = 1'b0; start_g = 1'b0; start_b = 1'b0;
    push(1'b0, V_IDLE, "post_reset", 2);
    push(1'b1, V_IDLE, "post_reset", 2);
    wait_cyc(2);

    rep_cnt = 4'd1; start_g = 1'b1;
    frame(1'b0, "single");
    push(1'b0, V_DONE, "single_done", 1);
    push(1'b0, V_IDLE, "single_idle", 1);
    wait_cyc(1); start_g = 1'b0; wait_cyc(5);

    rep_cnt = 4'd3; start_g = 1'b1;
    frame(1'b0, "rep3_f1"); push(1'b0, V_GAP, "rep3_gap1", 2);
    frame(1'b0, "rep3_f2"); push(1'b0, V_GAP, "rep3_gap2", 2);
    frame(1'b0, "rep3_f3");
    push(1'b0, V_DONE, "rep3_done", 1);
    push(1'b0, V_IDLE, "rep3_idle", 1);
    wait_cyc(1); start_g = 1'b0; wait_cyc(17);

    rep_cnt = 4'd0; start_g = 1'b1;
    push(1'b0, V_DONE, "zero_done", 1);
    push(1'b0, V_IDLE, "zero_idle", 2);
    wait_cyc(1); start_g = 1'b0; wait_cyc(2);

    rep_cnt = 4'd2; start_b = 1'b1;
    frame(1'b1, "b2b_f1"); frame(1'b1, "b2b_f2");
    push(1'b1, V_DONE, "b2b_done", 1);
    push(1'b1, V_IDLE, "b2b_idle", 1);
    wait_cyc(1); start_b = 1'b0; wait_cyc(9);

    rep_cnt = 4'd15; start_b = 1'b1;
    for (int i = 0; i < 15; i++) frame(1'b1, "rep15");
    push(1'b1, V_DONE, "rep15_done", 1);
    push(1'b1, V_IDLE, "rep15_idle", 1);
    wait_cyc(1); start_b = 1'b0; wait_cyc(61);

    // start re-pulsed mid-frame and during the DONE cycle is ignored
    rep_cnt = 4'd1; start_g = 1'b1;
    frame(1'b0, "ign_start");
    push(1'b0, V_DONE, "ign_done", 1);
    push(1'b0, V_IDLE, "ign_idle", 2);
    wait_cyc(1); start_g = 1'b0;
    wait_cyc(1); start_g = 1'b1;
    wait_cyc(1); start_g = 1'b0;
    wait_cyc(2); start_g = 1'b1;
    wait_cyc(1); start_g = 1'b0;
    wait_cyc(1);

    rep_cnt = 4'd2; start_g = 1'b1;
    push(1'b0, V_ONE, "abort_send", 2);
    push(1'b0, V_IDLE, "abort_send_idle", 4);
    wait_cyc(1); start_g = 1'b0;
    wait_cyc(1); abort = 1'b1;
    wait_cyc(1); abort = 1'b0;
    wait_cyc(3);

    rep_cnt = 4'd2; start_g = 1'b1;
    frame(1'b0, "abort_gap_f1");
    push(1'b0, V_GAP, "abort_gap", 1);
    push(1'b0, V_IDLE, "abort_gap_idle", 4);
    wait_cyc(1); start_g = 1'b0;
    wait_cyc(4); abort = 1'b1;
    wait_cyc(1); abort = 1'b0;
    wait_cyc(3);

    rep_cnt = 4'd1; start_g = 1'b1; abort = 1'b1;
    frame(1'b0, "abort_idle");
    push(1'b0, V_DONE, "abort_idle_done", 1);
    push(1'b0, V_IDLE, "abort_idle_idle", 1);
    wait_cyc(1); start_g = 1'b0; abort = 1'b0; wait_cyc(5);

    rep_cnt = 4'd1; start_g = 1'b1;
    push(1'b0, V_ONE, "rst_mid", 2);
    push(1'b0, V_ZERO, "rst_mid", 1);
    push(1'b0, V_IDLE, "rst_mid_idle", 3);
    wait_cyc(1); start_g = 1'b0;
    wait_cyc(2); rst = 1'b1;
    wait_cyc(1); rst = 1'b0;
    wait_cyc(2);

    // restart on the first IDLE cycle after done
    rep_cnt = 4'd1; start_b = 1'b1;
    frame(1'b1, "restart_f1");
    push(1'b1, V_DONE, "restart_done1", 1);
    push(1'b1, V_IDLE, "restart_idle1", 1);
    frame(1'b1, "restart_f2");
    push(1'b1, V_DONE, "restart_done2", 1);
    push(1'b1, V_IDLE, "restart_idle2", 1);
    wait_cyc(1); start_b = 1'b0;
    wait_cyc(5); start_b = 1'b1;
    wait_cyc(1); start_b = 1'b0;
    wait_cyc(5);

    wait_cyc(4);
    checks++;
    if (q_g.size() != 0 || q_b.size() != 0) begin
      errors++;
      $display("FAIL drain left=%0d required=0", q_g.size() + q_b.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
